// File: rtl/mgmt_uart_pkg.sv
// Shared types and constants for the management UART command bridge.
// Holds frame sync bytes, opcodes, response status codes and the checksum helper.
package mgmt_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OPCODE  = 3'd1,
    ST_ADDR    = 3'd2,
    ST_DATA    = 3'd3,
    ST_CSUM    = 3'd4,
    ST_EXEC    = 3'd5,
    ST_RD_WAIT = 3'd6,
    ST_RESP    = 3'd7
  } state_t;

  localparam logic [7:0] SYNC_CMD  = 8'hAA;
  localparam logic [7:0] SYNC_RESP = 8'h55;
  localparam logic [7:0] OP_READ   = 8'h01;
  localparam logic [7:0] OP_WRITE  = 8'h02;

  localparam logic [7:0] STAT_OK       = 8'h00;
  localparam logic [7:0] STAT_BAD_CSUM = 8'h01;
  localparam logic [7:0] STAT_BAD_OP   = 8'h02;
  localparam logic [7:0] STAT_RD_TMO   = 8'h03;

  function automatic logic [7:0] frame_csum(input logic [7:0] op,
                                            input logic [7:0] addr,
                                            input logic [7:0] data);
    return op ^ addr ^ data;
  endfunction

endpackage

// File: rtl/uart_tx_pacer.sv
// Byte-level transmit pacer: accepts a byte on valid/ready and issues a one-cycle tx_en,
// followed by a dead cycle, then waits for the UART to go idle before the next byte.
module uart_tx_pacer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx_en,
  output logic [7:0] tx_data,
  input  logic       tx_active
);

  logic       tx_en_r;
  logic [7:0] tx_data_r;

  // The pulse cycle itself blocks acceptance, which yields the mandatory dead cycle.
  assign ready   = ~tx_en_r & ~tx_active;
  assign tx_en   = tx_en_r;
  assign tx_data = tx_data_r;

  // Launch register for the transmit strobe and byte
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_en_r   <= 1'b0;
      tx_data_r <= 8'h00;
    end else begin
      tx_en_r <= valid & ready;
      if (valid && ready) begin
        tx_data_r <= data;
      end
    end
  end

endmodule

// File: rtl/mgmt_uart_bridge.sv
// Management command bridge: parses 5-byte UART command frames, performs one register
// access and returns a 3-byte response through the transmit pacer.
module mgmt_uart_bridge
  import mgmt_uart_pkg::*;
#(
  parameter int FRAME_TIMEOUT = 250000,
  parameter int RD_TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_en,
  output logic [7:0] tx_data,
  output logic       tx_en,
  input  logic       tx_active,
  output logic [7:0] reg_addr,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_data,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rd_data,
  input  logic       reg_rd_valid,
  output logic       busy,
  output logic [7:0] err_count
);

  localparam int FW = $clog2(FRAME_TIMEOUT);
  localparam int RW = $clog2(RD_TIMEOUT);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TIMEOUT - 1);
  localparam logic [RW-1:0] RD_LAST    = RW'(RD_TIMEOUT - 1);

  state_t        state_r, state_nxt_s;
  logic [1:0]    idx_r, idx_nxt_s;
  logic [FW-1:0] frame_cnt_r, frame_cnt_nxt_s;
  logic [RW-1:0] rd_cnt_r, rd_cnt_nxt_s;
  logic [7:0]    op_r, op_nxt_s, addr_r, addr_nxt_s, data_r, data_nxt_s;
  logic [7:0]    status_r, status_nxt_s, payload_r, payload_nxt_s;
  logic [7:0]    reg_addr_r, reg_addr_nxt_s, reg_wr_data_r, reg_wr_data_nxt_s;
  logic          reg_wr_en_r, wr_en_nxt_s, reg_rd_en_r, rd_en_nxt_s;
  logic          busy_r;
  logic [7:0]    err_count_r;
  logic          err_inc_s;
  logic          csum_ok_s;
  logic          send_valid_s, send_ready_s;
  logic [7:0]    send_data_s;

  assign csum_ok_s = (rx_data == frame_csum(op_r, addr_r, data_r));

  // Response byte selected by position within the 3-byte frame
  always_comb begin
    case (idx_r)
      2'd0:    send_data_s = SYNC_RESP;
      2'd1:    send_data_s = status_r;
      2'd2:    send_data_s = payload_r;
      default: send_data_s = 8'h00;
    endcase
  end

  // Next-state and datapath decisions for the command FSM
  always_comb begin
    state_nxt_s       = state_r;
    idx_nxt_s         = idx_r;
    frame_cnt_nxt_s   = '0;
    rd_cnt_nxt_s      = '0;
    op_nxt_s          = op_r;
    addr_nxt_s        = addr_r;
    data_nxt_s        = data_r;
    status_nxt_s      = status_r;
    payload_nxt_s     = payload_r;
    reg_addr_nxt_s    = reg_addr_r;
    reg_wr_data_nxt_s = reg_wr_data_r;
    wr_en_nxt_s       = 1'b0;
    rd_en_nxt_s       = 1'b0;
    err_inc_s         = 1'b0;
    send_valid_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        idx_nxt_s = 2'd0;
        if (rx_en && rx_data == SYNC_CMD) begin
          state_nxt_s = ST_OPCODE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_OPCODE, ST_ADDR, ST_DATA, ST_CSUM: begin
        // A byte arriving in the expiry cycle takes priority over the timeout.
        if (rx_en) begin
          case (state_r)
            ST_OPCODE: begin
              op_nxt_s    = rx_data;
              state_nxt_s = ST_ADDR;
            end
            ST_ADDR: begin
              addr_nxt_s  = rx_data;
              state_nxt_s = ST_DATA;
            end
            ST_DATA: begin
              data_nxt_s  = rx_data;
              state_nxt_s = ST_CSUM;
            end
            default: begin
              state_nxt_s       = ST_EXEC;
              reg_addr_nxt_s    = addr_r;
              reg_wr_data_nxt_s = data_r;
              payload_nxt_s     = 8'h00;
              if (!csum_ok_s) begin
                status_nxt_s = STAT_BAD_CSUM;
                err_inc_s    = 1'b1;
              end else if (op_r == OP_WRITE) begin
                status_nxt_s = STAT_OK;
                wr_en_nxt_s  = 1'b1;
              end else if (op_r == OP_READ) begin
                status_nxt_s = STAT_OK;
                rd_en_nxt_s  = 1'b1;
              end else begin
                status_nxt_s = STAT_BAD_OP;
                err_inc_s    = 1'b1;
              end
            end
          endcase
        end else if (frame_cnt_r == FRAME_LAST) begin
          state_nxt_s = ST_IDLE;
          err_inc_s   = 1'b1;
        end else begin
          frame_cnt_nxt_s = frame_cnt_r + FW'(1);
        end
      end
      ST_EXEC: begin
        if (status_r == STAT_OK && op_r == OP_READ) begin
          state_nxt_s = ST_RD_WAIT;
        end else begin
          send_valid_s = 1'b1;
          state_nxt_s  = ST_RESP;
          if (send_ready_s) begin
            idx_nxt_s = idx_r + 2'd1;
          end else begin
            idx_nxt_s = idx_r;
          end
        end
      end
      ST_RD_WAIT: begin
        if (reg_rd_valid || rd_cnt_r == RD_LAST) begin
          // The completion (or timeout) cycle already offers the sync byte.
          send_valid_s = 1'b1;
          state_nxt_s  = ST_RESP;
          if (reg_rd_valid) begin
            payload_nxt_s = reg_rd_data;
          end else begin
            status_nxt_s = STAT_RD_TMO;
            err_inc_s    = 1'b1;
          end
          if (send_ready_s) begin
            idx_nxt_s = idx_r + 2'd1;
          end else begin
            idx_nxt_s = idx_r;
          end
        end else begin
          rd_cnt_nxt_s = rd_cnt_r + RW'(1);
        end
      end
      ST_RESP: begin
        // idx 3 is the cycle the last byte's tx_en is on the wire.
        if (idx_r == 2'd3) begin
          state_nxt_s = ST_IDLE;
          idx_nxt_s   = 2'd0;
        end else begin
          send_valid_s = 1'b1;
          if (send_ready_s) begin
            idx_nxt_s = idx_r + 2'd1;
          end else begin
            idx_nxt_s = idx_r;
          end
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      idx_r         <= 2'd0;
      frame_cnt_r   <= '0;
      rd_cnt_r      <= '0;
      op_r          <= 8'h00;
      addr_r        <= 8'h00;
      data_r        <= 8'h00;
      status_r      <= 8'h00;
      payload_r     <= 8'h00;
      reg_addr_r    <= 8'h00;
      reg_wr_data_r <= 8'h00;
      reg_wr_en_r   <= 1'b0;
      reg_rd_en_r   <= 1'b0;
      busy_r        <= 1'b0;
      err_count_r   <= 8'h00;
    end else begin
      state_r       <= state_nxt_s;
      idx_r         <= idx_nxt_s;
      frame_cnt_r   <= frame_cnt_nxt_s;
      rd_cnt_r      <= rd_cnt_nxt_s;
      op_r          <= op_nxt_s;
      addr_r        <= addr_nxt_s;
      data_r        <= data_nxt_s;
      status_r      <= status_nxt_s;
      payload_r     <= payload_nxt_s;
      reg_addr_r    <= reg_addr_nxt_s;
      reg_wr_data_r <= reg_wr_data_nxt_s;
      reg_wr_en_r   <= wr_en_nxt_s;
      reg_rd_en_r   <= rd_en_nxt_s;
      busy_r        <= (state_nxt_s != ST_IDLE);
      if (err_inc_s && err_count_r != 8'hFF) begin
        err_count_r <= err_count_r + 8'd1;
      end
    end
  end

  assign reg_addr    = reg_addr_r;
  assign reg_wr_data = reg_wr_data_r;
  assign reg_wr_en   = reg_wr_en_r;
  assign reg_rd_en   = reg_rd_en_r;
  assign busy        = busy_r;
  assign err_count   = err_count_r;

  uart_tx_pacer u_pacer (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (send_valid_s),
    .data      (send_data_s),
    .ready     (send_ready_s),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .tx_active (tx_active)
  );

endmodule

// File: tb/tb_mgmt_uart_bridge.sv
// Randomized self-checking bench for mgmt_uart_bridge with a transaction-level reference
// model, a register-file responder and a UART busy model.
module tb_mgmt_uart_bridge;

  localparam int FT = 200;
  localparam int RT = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_en = 1'b0;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_active = 1'b0;
  logic [7:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wr_data;
  logic       reg_rd_en;
  logic [7:0] reg_rd_data = 8'h00;
  logic       reg_rd_valid = 1'b0;
  logic       busy;
  logic [7:0] err_count;

  mgmt_uart_bridge #(.FRAME_TIMEOUT(FT), .RD_TIMEOUT(RT)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_en(rx_en),
    .tx_data(tx_data), .tx_en(tx_en), .tx_active(tx_active),
    .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
    .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  int err_exp = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Observation state kept by the monitor / environment models
  logic [7:0] tx_q[$];
  int         tx_cyc_q[$];
  int         wr_cnt = 0, wr_cyc = 0, rd_cnt = 0, rd_cyc = 0;
  logic [7:0] wr_addr = 8'h00, wr_data = 8'h00, rd_addr = 8'h00;
  int         uart_len = 0, busy_left = 0, hold_until = 0, last_tx = -10;
  int         rd_delay = -1, rd_left = 0, busy_fall = 0;
  logic       prev_act = 1'b0, prev_busy = 1'b0;
  logic [7:0] mem [256];

  // Monitor, UART busy model and register read responder
  always @(negedge clk) begin
    if (tx_en) begin
      chk("tx_spacing", 32'(cyc - last_tx >= 2), 32'd1);
      chk("tx_while_active", 32'(prev_act), 32'd0);
      tx_q.push_back(tx_data);
      tx_cyc_q.push_back(cyc);
      last_tx = cyc;
      busy_left = uart_len;
    end
    tx_active = (busy_left > 0) || (cyc < hold_until);
    if (busy_left > 0) busy_left--;
    prev_act = tx_active;
    if (reg_wr_en) begin
      wr_cnt++; wr_addr = reg_addr; wr_data = reg_wr_data; wr_cyc = cyc;
    end
    reg_rd_valid = 1'b0;
    reg_rd_data = 8'($urandom);
    if (rd_left > 0) begin
      rd_left--;
      if (rd_left == 0) begin
        reg_rd_valid = 1'b1;
        reg_rd_data = mem[rd_addr];
      end
    end
    if (reg_rd_en) begin
      rd_cnt++; rd_cyc = cyc; rd_addr = reg_addr;
      rd_left = (rd_delay > 0) ? rd_delay : 0;
    end
    if (prev_busy && !busy) busy_fall = cyc;
    prev_busy = busy;
  end

  function automatic int bump(input int e);
    return (e >= 255) ? 255 : e + 1;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap, output int c);
    repeat (gap - 1) @(negedge clk);
    rx_data = b;
    rx_en = 1'b1;
    c = cyc;
    @(negedge clk);
    rx_en = 1'b0;
  endtask

  function automatic int pick_gap(input int gmax);
    return 1 + int'($urandom_range(gmax - 1, 0));
  endfunction

  task automatic run_cmd(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] data,
                         input bit bad, input int delay, input int gmax, input int ulen,
                         input int gapfix, input bit hold);
    logic [7:0] csum, exp_st, exp_pay;
    int c, tcs, base, wr0, rd0, exp_first, exp_gap, k, dummy;
    bit exp_wr, exp_rd, held;
    csum = op ^ addr ^ data;
    if (bad) csum = csum ^ (8'h01 << $urandom_range(7, 0));
    rd_delay = delay; uart_len = ulen;
    base = tx_q.size(); wr0 = wr_cnt; rd0 = rd_cnt; held = 1'b0;
    send_byte(8'hAA, pick_gap(3), c);
    send_byte(op, pick_gap(gmax), c);
    send_byte(addr, pick_gap(gmax), c);
    send_byte(data, pick_gap(gmax), c);
    send_byte(csum, (gapfix > 0) ? gapfix : pick_gap(gmax), tcs);
    exp_wr = 1'b0; exp_rd = 1'b0; exp_pay = 8'h00; exp_first = tcs + 2;
    if (bad) begin
      exp_st = 8'h01; err_exp = bump(err_exp);
    end else if (op == 8'h02) begin
      exp_st = 8'h00; exp_wr = 1'b1; mem[addr] = data;
    end else if (op == 8'h01) begin
      exp_rd = 1'b1;
      if (delay >= 1 && delay <= RT) begin
        exp_st = 8'h00; exp_pay = mem[addr]; exp_first = tcs + 2 + delay;
      end else begin
        exp_st = 8'h03; exp_first = tcs + 2 + RT; err_exp = bump(err_exp);
      end
    end else begin
      exp_st = 8'h02; err_exp = bump(err_exp);
    end
    k = 0;
    while (tx_q.size() < base + 3 && k < 2000) begin
      if (hold && !held && tx_q.size() > base) begin
        held = 1'b1;
        hold_until = cyc + 500;
        send_byte(8'hAA, 1, dummy);
        send_byte(8'h02, 1, dummy);
      end
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    if (tx_q.size() < base + 3) begin
      chk("resp_len", 32'(tx_q.size() - base), 32'd3);
    end else begin
      chk("resp_sync", 32'(tx_q[base]), 32'h55);
      chk("resp_status", 32'(tx_q[base + 1]), 32'(exp_st));
      chk("resp_payload", 32'(tx_q[base + 2]), 32'(exp_pay));
      chk("first_tx_cyc", 32'(tx_cyc_q[base]), 32'(exp_first));
      if (hold) begin
        chk("tx_hold", 32'(tx_cyc_q[base + 1] > hold_until), 32'd1);
      end else begin
        exp_gap = (ulen + 1 > 2) ? ulen + 1 : 2;
        chk("tx_gap1", 32'(tx_cyc_q[base + 1] - tx_cyc_q[base]), 32'(exp_gap));
        chk("tx_gap2", 32'(tx_cyc_q[base + 2] - tx_cyc_q[base + 1]), 32'(exp_gap));
      end
      chk("idle_cyc", 32'(busy_fall), 32'(tx_cyc_q[base + 2] + 1));
    end
    chk("busy_idle", 32'(busy), 32'd0);
    chk("wr_pulses", 32'(wr_cnt - wr0), 32'(exp_wr));
    if (exp_wr) begin
      chk("wr_addr", 32'(wr_addr), 32'(addr));
      chk("wr_data", 32'(wr_data), 32'(data));
      chk("wr_cyc", 32'(wr_cyc), 32'(tcs + 1));
    end
    chk("rd_pulses", 32'(rd_cnt - rd0), 32'(exp_rd));
    if (exp_rd) begin
      chk("rd_addr", 32'(rd_addr), 32'(addr));
      chk("rd_cyc", 32'(rd_cyc), 32'(tcs + 1));
    end
    chk("err_count", 32'(err_count), 32'(err_exp));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_tx_en"}, 32'(tx_en), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_wr_en"}, 32'(reg_wr_en), 32'd0);
    chk({tag, "_rd_en"}, 32'(reg_rd_en), 32'd0);
    chk({tag, "_addr"}, 32'(reg_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(reg_wr_data), 32'd0);
    chk({tag, "_err"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, required below 100000", cyc);
    $fatal(1);
  end

  initial begin
    int c, cb, base, wr0, r, dly;
    logic [7:0] op, a, d;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h20] = 8'h3C;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed scenarios
    run_cmd(8'h02, 8'h10, 8'h5C, 1'b0, -1, 1, 0, 0, 1'b0);
    run_cmd(8'h01, 8'h20, 8'h00, 1'b0, 3, 1, 0, 0, 1'b0);
    run_cmd(8'h02, 8'h10, 8'h5C, 1'b1, -1, 1, 0, 0, 1'b0);
    run_cmd(8'h07, 8'h00, 8'h00, 1'b0, -1, 1, 0, 0, 1'b0);
    run_cmd(8'h01, 8'h20, 8'h00, 1'b0, -1, 1, 0, 0, 1'b0);
    run_cmd(8'h01, 8'h21, 8'h00, 1'b0, RT, 2, 0, 0, 1'b0);
    run_cmd(8'h01, 8'h22, 8'h00, 1'b0, RT + 1, 2, 0, 0, 1'b0);
    run_cmd(8'h01, 8'h23, 8'h00, 1'b0, 1, 2, 0, 0, 1'b0);

    // Noise byte, partial frame, then stall until the frame timer expires
    wr0 = wr_cnt;
    base = tx_q.size();
    send_byte(8'h41, 3, c);
    send_byte(8'hAA, 2, c);
    send_byte(8'h02, 1, cb);
    repeat (FT + 3) @(negedge clk);
    err_exp = bump(err_exp);
    chk("ft_idle_cyc", 32'(busy_fall), 32'(cb + FT + 1));
    chk("ft_busy", 32'(busy), 32'd0);
    chk("ft_no_resp", 32'(tx_q.size()), 32'(base));
    chk("ft_no_wr", 32'(wr_cnt), 32'(wr0));
    chk("ft_err", 32'(err_count), 32'(err_exp));
    run_cmd(8'h02, 8'h44, 8'h99, 1'b0, -1, 3, 2, 0, 1'b0);
    run_cmd(8'h02, 8'h45, 8'h9A, 1'b0, -1, 2, 0, FT, 1'b0);
    run_cmd(8'h02, 8'h46, 8'h9B, 1'b0, -1, 1, 0, 0, 1'b1);

    // Randomized command mix
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(9, 0));
      a = 8'($urandom);
      d = 8'($urandom);
      if (r < 4 || r == 9) op = 8'h02;
      else if (r < 8) op = 8'h01;
      else begin
        op = 8'($urandom);
        if (op == 8'h01 || op == 8'h02) op = 8'h80;
      end
      case ($urandom_range(5, 0))
        0: dly = RT;
        1: dly = RT + 1;
        2: dly = -1;
        default: dly = 1 + int'($urandom_range(7, 0));
      endcase
      run_cmd(op, a, d, ($urandom_range(5, 0) == 0), dly, 4, int'($urandom_range(4, 0)), 0, 1'b0);
    end

    // Drive the error counter into saturation
    while (err_exp < 255) run_cmd(8'h02, 8'($urandom), 8'($urandom), 1'b1, -1, 1, 0, 0, 1'b0);
    repeat (3) run_cmd(8'h07, 8'h01, 8'h02, 1'b0, -1, 1, 0, 0, 1'b0);

    // Reset between response bytes
    uart_len = 3;
    base = tx_q.size();
    send_byte(8'hAA, 1, c);
    send_byte(8'h02, 1, c);
    send_byte(8'h33, 1, c);
    send_byte(8'h44, 1, c);
    send_byte(8'h02 ^ 8'h33 ^ 8'h44, 1, c);
    for (int k = 0; k < 50 && tx_q.size() == base; k++) @(negedge clk);
    chk("rst_first_byte", 32'(tx_q.size() - base), 32'd1);
    rst_n = 1'b0;
    base = tx_q.size();
    repeat (2) @(negedge clk);
    chk_zero_outputs("midrst");
    rst_n = 1'b1;
    err_exp = 0;
    mem[8'h33] = 8'h44;
    repeat (12) @(negedge clk);
    chk("rst_no_more_tx", 32'(tx_q.size()), 32'(base));
    run_cmd(8'h02, 8'h55, 8'hA5, 1'b0, -1, 1, 0, 0, 1'b0);
    run_cmd(8'h01, 8'h33, 8'h00, 1'b0, 5, 1, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
